// File: rtl/extif_in_feed_pkg.sv
// Shared types for the extif IN ingress stage: byte width and the {last,data} FIFO entry.
package extif_in_feed_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } in_entry_t;

endpackage

// File: rtl/extif_in_feed_if.sv
// extif IN handshake: the feed drives head data/valid, the extif stage returns ready.
interface extif_in_feed_if;
  import extif_in_feed_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_last, output in_valid, input in_ready);
  modport slave  (input in_data, input in_last, input in_valid, output in_ready);

endinterface

// File: rtl/extif_in_feed_fifo_sync_ram.sv
// Generic first-word-fall-through FIFO; pointers carry a wrap bit so full/empty need no counter.
module fifo_sync_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  always_comb begin
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty   = (wr_ptr == rd_ptr);
    push    = wr_en & ~full;
    pop     = rd_en & ~empty;
    level   = wr_ptr - rd_ptr;
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  // Storage is not reset; resetting the pointers is what discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/extif_in_feed.sv
// User-side ingress for the extif IN path: byte FIFO plus the flush-now and idle-timeout flags.
module extif_in_feed
  import extif_in_feed_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       u_data,
  input  logic                    u_last,
  input  logic                    u_valid,
  output logic                    u_ready,
  input  logic                    u_flush,
  output logic [$clog2(DEPTH):0]  level,
  extif_in_feed_if.master         in_if,
  output logic                    in_flush_now,
  output logic                    in_flush_time
);

  in_entry_t     wr_entry;
  in_entry_t     rd_entry;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          pend, pend_d;
  logic          dirty, dirty_d;
  logic [TW-1:0] timer, timer_d;
  logic          flush_now_d;
  logic          flush_time_d;

  fifo_sync_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_entry),
    .wr_en   (u_valid),
    .full    (full),
    .rd_data (rd_entry),
    .rd_en   (in_if.in_ready),
    .empty   (empty),
    .level   (level)
  );

  // Handshake outputs depend on FIFO state only, never on the opposite side's strobe.
  always_comb begin
    wr_entry.last   = u_last;
    wr_entry.data   = u_data;
    u_ready         = ~full;
    in_if.in_valid  = ~empty;
    in_if.in_data   = rd_entry.data;
    in_if.in_last   = rd_entry.last;
    push            = u_valid & ~full;
    pop             = in_if.in_ready & ~empty;
  end

  // A flush in the same cycle as a push wins, so the request is not lost.
  always_comb begin
    pend_d       = pend;
    dirty_d      = dirty;
    timer_d      = timer;
    flush_now_d  = pend & empty;
    flush_time_d = dirty & (timer == TW'(TIMEOUT));

    if (u_flush) begin
      pend_d = 1'b1;
    end else if (push) begin
      pend_d = 1'b0;
    end

    if (pop) begin
      dirty_d = ~rd_entry.last;
    end

    if (push || pop) begin
      timer_d = '0;
    end else if (dirty && empty && (timer != TW'(TIMEOUT))) begin
      timer_d = timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend          <= 1'b0;
      dirty         <= 1'b0;
      timer         <= '0;
      in_flush_now  <= 1'b0;
      in_flush_time <= 1'b0;
    end else begin
      pend          <= pend_d;
      dirty         <= dirty_d;
      timer         <= timer_d;
      in_flush_now  <= flush_now_d;
      in_flush_time <= flush_time_d;
    end
  end

endmodule

// File: tb/tb_extif_in_feed.sv
// Directed bench for extif_in_feed (DEPTH=16, TIMEOUT=8): FIFO ordering, full/empty edges, flush flags, reset.
module tb_extif_in_feed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] u_data = 8'h00;
  logic       u_last = 1'b0;
  logic       u_valid = 1'b0;
  logic       u_ready;
  logic       u_flush = 1'b0;
  logic [4:0] level;
  logic       in_flush_now;
  logic       in_flush_time;

  int n_checks = 0;
  int n_fail   = 0;

  extif_in_feed_if bus ();

  extif_in_feed #(
    .DEPTH   (16),
    .TIMEOUT (8),
    .TW      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .u_data        (u_data),
    .u_last        (u_last),
    .u_valid       (u_valid),
    .u_ready       (u_ready),
    .u_flush       (u_flush),
    .level         (level),
    .in_if         (bus),
    .in_flush_now  (in_flush_now),
    .in_flush_time (in_flush_time)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sb(input int k);
    return 8'(k * 3 + 7);
  endfunction

  task automatic test_reset();
    bus.in_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (u_ready !== 1'b1) begin n_fail++; $display("FAIL reset_u_ready: got %b expected 1", u_ready); end
    n_checks++;
    if (bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b expected 0", bus.in_valid); end
    n_checks++;
    if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++;
    if ({in_flush_now, in_flush_time} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {in_flush_now, in_flush_time});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_push3();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    bus.in_ready = 1'b0;
    u_valid = 1'b1; u_data = vals[0]; u_last = 1'b0;
    tick();
    n_checks++;
    if (bus.in_valid !== 1'b1 || bus.in_data !== 8'h11) begin
      n_fail++; $display("FAIL push3_first_latency: got valid=%b data=%h expected valid=1 data=11", bus.in_valid, bus.in_data);
    end
    u_data = vals[1];
    tick();
    u_data = vals[2]; u_last = 1'b1;
    tick();
    u_valid = 1'b0; u_last = 1'b0;
    n_checks++;
    if (level !== 5'd3) begin n_fail++; $display("FAIL push3_level: got %0d expected 3", level); end
    n_checks++;
    if (bus.in_data !== 8'h11) begin n_fail++; $display("FAIL push3_head: got %h expected 11", bus.in_data); end
    bus.in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.in_data !== vals[i] || bus.in_last !== (i == 2)) begin
        n_fail++; $display("FAIL push3_drain[%0d]: got data=%h last=%b expected data=%h last=%b", i, bus.in_data, bus.in_last, vals[i], (i == 2));
      end
      tick();
    end
    bus.in_ready = 1'b0;
    n_checks++;
    if (bus.in_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++; $display("FAIL push3_empty: got valid=%b level=%0d expected valid=0 level=0", bus.in_valid, level);
    end
    // in_ready pulse while empty must not disturb anything
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    n_checks++;
    if (level !== 5'd0 || u_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_while_empty: got level=%0d u_ready=%b expected 0 and 1", level, u_ready);
    end
  endtask

  task automatic test_full();
    bus.in_ready = 1'b0;
    u_valid = 1'b1; u_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      u_data = 8'(i + 1);
      tick();
    end
    n_checks++;
    if (u_ready !== 1'b0 || level !== 5'd16) begin
      n_fail++; $display("FAIL full_state: got u_ready=%b level=%0d expected 0 and 16", u_ready, level);
    end
    u_data = 8'hAA; u_last = 1'b1;
    tick();
    n_checks++;
    if (level !== 5'd16 || bus.in_data !== 8'h01) begin
      n_fail++; $display("FAIL full_no_push: got level=%0d head=%h expected 16 and 01", level, bus.in_data);
    end
    u_valid = 1'b0;
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    n_checks++;
    if (u_ready !== 1'b1 || level !== 5'd15) begin
      n_fail++; $display("FAIL full_pop_ready: got u_ready=%b level=%0d expected 1 and 15", u_ready, level);
    end
    u_valid = 1'b1;
    tick();
    u_valid = 1'b0; u_last = 1'b0;
    n_checks++;
    if (level !== 5'd16 || u_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_17th_push: got level=%0d u_ready=%b expected 16 and 0", level, u_ready);
    end
    bus.in_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 15) ? 8'hAA : 8'(i + 2);
      n_checks++;
      if (bus.in_data !== exp_d || bus.in_last !== (i == 15)) begin
        n_fail++; $display("FAIL full_drain[%0d]: got data=%h last=%b expected data=%h last=%b", i, bus.in_data, bus.in_last, exp_d, (i == 15));
      end
      tick();
    end
    bus.in_ready = 1'b0;
    n_checks++;
    if (bus.in_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got valid=%b expected 0", bus.in_valid); end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    bus.in_ready = 1'b1;
    u_valid = 1'b1; u_data = sb(0); u_last = 1'b0;
    tick();
    for (int k = 1; k < 100; k++) begin
      u_data = sb(k);
      u_last = (k == 49) || (k == 99);
      n_checks++;
      if (bus.in_data !== sb(k - 1) || bus.in_last !== ((k - 1) == 49) || level !== 5'd1) begin
        n_fail++; errs++;
        if (errs < 5) $display("FAIL stream[%0d]: got data=%h last=%b level=%0d expected data=%h last=%b level=1",
                               k - 1, bus.in_data, bus.in_last, level, sb(k - 1), ((k - 1) == 49));
      end
      tick();
    end
    u_valid = 1'b0; u_last = 1'b0;
    n_checks++;
    if (bus.in_data !== sb(99) || bus.in_last !== 1'b1) begin
      n_fail++; $display("FAIL stream_tail: got data=%h last=%b expected data=%h last=1", bus.in_data, bus.in_last, sb(99));
    end
    tick();
    bus.in_ready = 1'b0;
    n_checks++;
    if (bus.in_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++; $display("FAIL stream_empty: got valid=%b level=%0d expected 0 and 0", bus.in_valid, level);
    end
  endtask

  task automatic test_flush_now();
    bus.in_ready = 1'b0;
    u_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_data = 8'(8'h50 + i); u_last = (i == 4);
      tick();
    end
    u_valid = 1'b0; u_last = 1'b0;
    u_flush = 1'b1;
    tick();
    u_flush = 1'b0;
    n_checks++;
    if (in_flush_now !== 1'b0) begin n_fail++; $display("FAIL flush_now_with_data: got %b expected 0", in_flush_now); end
    bus.in_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.in_ready = 1'b0;
    n_checks++;
    if (in_flush_now !== 1'b0) begin n_fail++; $display("FAIL flush_now_at_last_pop: got %b expected 0", in_flush_now); end
    tick();
    n_checks++;
    if (in_flush_now !== 1'b1) begin n_fail++; $display("FAIL flush_now_assert: got %b expected 1", in_flush_now); end
    u_valid = 1'b1; u_data = 8'h77; u_last = 1'b1;
    tick();
    u_valid = 1'b0; u_last = 1'b0;
    n_checks++;
    if (in_flush_now !== 1'b1) begin n_fail++; $display("FAIL flush_now_hold: got %b expected 1", in_flush_now); end
    tick();
    n_checks++;
    if (in_flush_now !== 1'b0) begin n_fail++; $display("FAIL flush_now_drop: got %b expected 0", in_flush_now); end
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    tick();
    n_checks++;
    if (in_flush_now !== 1'b0) begin n_fail++; $display("FAIL flush_now_stays_clear: got %b expected 0", in_flush_now); end
  endtask

  task automatic test_flush_time();
    bus.in_ready = 1'b0;
    u_valid = 1'b1; u_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_data = 8'(8'h90 + i);
      tick();
    end
    u_valid = 1'b0;
    bus.in_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.in_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (in_flush_time !== 1'b0) begin n_fail++; $display("FAIL flush_time_early[%0d]: got %b expected 0", i, in_flush_time); end
    end
    tick();
    n_checks++;
    if (in_flush_time !== 1'b1) begin n_fail++; $display("FAIL flush_time_assert: got %b expected 1", in_flush_time); end
    u_valid = 1'b1; u_data = 8'hEE; u_last = 1'b1;
    tick();
    u_valid = 1'b0; u_last = 1'b0;
    tick();
    n_checks++;
    if (in_flush_time !== 1'b0) begin n_fail++; $display("FAIL flush_time_push_clear: got %b expected 0", in_flush_time); end
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (in_flush_time !== 1'b0) begin n_fail++; $display("FAIL flush_time_after_last: got %b expected 0", in_flush_time); end
  endtask

  task automatic test_reset_mid();
    bus.in_ready = 1'b0;
    u_valid = 1'b1; u_last = 1'b0;
    for (int i = 0; i < 7; i++) begin
      u_data = 8'(8'hC0 + i);
      tick();
    end
    u_valid = 1'b0;
    n_checks++;
    if (level !== 5'd7) begin n_fail++; $display("FAIL mid_level_before: got %0d expected 7", level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_valid !== 1'b0 || level !== 5'd0 || u_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b level=%0d u_ready=%b expected 0 0 1", bus.in_valid, level, u_ready);
    end
    n_checks++;
    if ({in_flush_now, in_flush_time} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_flags: got %b expected 00", {in_flush_now, in_flush_time});
    end
    tick();
    rst_n = 1'b1;
    tick();
    u_valid = 1'b1; u_data = 8'h3C; u_last = 1'b1;
    tick();
    u_valid = 1'b0; u_last = 1'b0;
    n_checks++;
    if (level !== 5'd1 || bus.in_data !== 8'h3C) begin
      n_fail++; $display("FAIL mid_reset_recover: got level=%0d data=%h expected 1 and 3c", level, bus.in_data);
    end
  endtask

  initial begin
    bus.in_ready = 1'b0;
    test_reset();
    test_push3();
    test_full();
    test_back_to_back();
    test_flush_now();
    test_flush_time();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
